// File: rtl/mem_pkg.sv
// Shared types, one-hot field indices and lane helpers for the MEM pipeline stage.
package mem_pkg;

  localparam int unsigned DW      = 32;
  localparam int unsigned LOAD_W  = 5;
  localparam int unsigned STORE_W = 3;

  localparam int unsigned LOAD_LB  = 0;
  localparam int unsigned LOAD_LH  = 1;
  localparam int unsigned LOAD_LW  = 2;
  localparam int unsigned LOAD_LBU = 3;
  localparam int unsigned LOAD_LHU = 4;

  localparam int unsigned STORE_SB = 0;
  localparam int unsigned STORE_SH = 1;
  localparam int unsigned STORE_SW = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Everything needed to keep driving an access and to build MEM/WB when it retires.
  typedef struct packed {
    logic [DW-1:0]      addr;
    logic [DW-1:0]      wdata;
    logic [LOAD_W-1:0]  loadcntrl;
    logic [STORE_W-1:0] storecntrl;
    logic [4:0]         rd;
    logic [DW-1:0]      pc;
    logic [DW-1:0]      csr;
    logic               regwrite;
    logic               is_load;
    logic               is_store;
    logic               fpusrc;
    logic               csr_read;
  } req_t;

  function automatic logic [3:0] lane_en(input logic [STORE_W-1:0] sc, input logic [1:0] off,
                                         input logic is_store);
    logic [3:0] en;
    en = 4'b1111;
    if (is_store) begin
      if (sc[STORE_SB])      en = 4'b0001 << off;
      else if (sc[STORE_SH]) en = 4'b0011 << off;
    end
    return en;
  endfunction

  function automatic logic [DW-1:0] store_data(input logic [STORE_W-1:0] sc, input logic [DW-1:0] rs2);
    logic [DW-1:0] d;
    d = rs2;
    if (sc[STORE_SB])      d = {4{rs2[7:0]}};
    else if (sc[STORE_SH]) d = {2{rs2[15:0]}};
    return d;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready port between the MEM stage and data memory.
interface mem_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_din;
  logic [XLEN-1:0] mem_dout;
  logic [3:0]      mem_en;
  logic            mem_wea;
  logic            mem_rea;
  logic            mem_rdy;

  modport master (
    output mem_addr, mem_din, mem_en, mem_wea, mem_rea,
    input  mem_dout, mem_rdy
  );

  modport slave (
    input  mem_addr, mem_din, mem_en, mem_wea, mem_rea,
    output mem_dout, mem_rdy
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half/word out of a read word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [DW-1:0]     dout,
  input  logic [1:0]        offset,
  input  logic [LOAD_W-1:0] loadcntrl,
  output logic [DW-1:0]     load_data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v      = dout[{offset, 3'b000} +: 8];
    half_v      = dout[{offset[1], 4'b0000} +: 16];
    load_data_c = dout;
    if (loadcntrl[LOAD_LB])       load_data_c = {{24{byte_v[7]}}, byte_v};
    else if (loadcntrl[LOAD_LBU]) load_data_c = {24'h0, byte_v};
    else if (loadcntrl[LOAD_LH])  load_data_c = {{16{half_v[15]}}, half_v};
    else if (loadcntrl[LOAD_LHU]) load_data_c = {16'h0, half_v};
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores over a request/ready port and builds the MEM/WB registers.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned XLEN    = 32
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic [XLEN-1:0]    EX_MEM_alures,
  input  logic [XLEN-1:0]    EX_MEM_dout_rs2,
  input  logic [4:0]         EX_MEM_rd,
  input  logic               EX_MEM_regwrite,
  input  logic               EX_MEM_memread,
  input  logic               EX_MEM_memwrite,
  input  logic [LOAD_W-1:0]  EX_MEM_loadcntrl,
  input  logic [STORE_W-1:0] EX_MEM_storecntrl,
  input  logic [XLEN-1:0]    EX_MEM_pres_addr,
  input  logic               EX_MEM_fpusrc,
  input  logic [XLEN-1:0]    EX_MEM_CSR,
  input  logic               EX_MEM_CSR_read,
  mem_stage_if.master        mem,
  output logic               mem_hold,
  output logic               bus_err,
  output logic               misalign,
  output logic [4:0]         MEM_WB_rd,
  output logic               MEM_WB_regwrite,
  output logic               MEM_WB_memread,
  output logic               MEM_WB_fpusrc,
  output logic               MEM_WB_CSR_read,
  output logic [XLEN-1:0]    MEM_WB_alures,
  output logic [XLEN-1:0]    MEM_WB_memres,
  output logic [XLEN-1:0]    MEM_WB_pres_addr,
  output logic [XLEN-1:0]    MEM_WB_CSR
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  state_e          state_q, state_d;
  req_t            req_q, ex_req, cur;
  logic [CNT_W-1:0] cnt_q;
  logic            ex_access, ex_mis, issue_c, timeout_c;
  logic [DW-1:0]   load_data_c;

  // Incoming EX/MEM request; a store overrides a simultaneous load.
  always_comb begin
    ex_req            = '0;
    ex_req.addr       = EX_MEM_alures;
    ex_req.wdata      = EX_MEM_dout_rs2;
    ex_req.loadcntrl  = EX_MEM_loadcntrl;
    ex_req.storecntrl = EX_MEM_storecntrl;
    ex_req.rd         = EX_MEM_rd;
    ex_req.pc         = EX_MEM_pres_addr;
    ex_req.csr        = EX_MEM_CSR;
    ex_req.regwrite   = EX_MEM_regwrite;
    ex_req.is_store   = EX_MEM_memwrite;
    ex_req.is_load    = EX_MEM_memread & ~EX_MEM_memwrite;
    ex_req.fpusrc     = EX_MEM_fpusrc;
    ex_req.csr_read   = EX_MEM_CSR_read;
    ex_access = EX_MEM_memread | EX_MEM_memwrite;
    if (ex_req.is_store)
      ex_mis = (EX_MEM_storecntrl[STORE_SH] & EX_MEM_alures[0]) |
               (EX_MEM_storecntrl[STORE_SW] & (|EX_MEM_alures[1:0]));
    else
      ex_mis = ((EX_MEM_loadcntrl[LOAD_LH] | EX_MEM_loadcntrl[LOAD_LHU]) & EX_MEM_alures[0]) |
               (EX_MEM_loadcntrl[LOAD_LW] & (|EX_MEM_alures[1:0]));
    issue_c   = ex_access & ~ex_mis;
    timeout_c = (state_q == WAIT) && !mem.mem_rdy && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue_c) state_d = WAIT;
      WAIT:    if (mem.mem_rdy || timeout_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port: the live EX/MEM request on the issue cycle, the latched one while waiting.
  always_comb begin
    cur          = (state_q == WAIT) ? req_q : ex_req;
    mem.mem_addr = '0;
    mem.mem_din  = '0;
    mem.mem_en   = '0;
    mem.mem_wea  = 1'b0;
    mem.mem_rea  = 1'b0;
    mem_hold     = 1'b0;
    if (!Rst && (state_q == WAIT || issue_c)) begin
      mem.mem_addr = {cur.addr[DW-1:2], 2'b00};
      mem.mem_din  = cur.is_store ? store_data(cur.storecntrl, cur.wdata) : '0;
      mem.mem_en   = lane_en(cur.storecntrl, cur.addr[1:0], cur.is_store);
      mem.mem_wea  = cur.is_store;
      mem.mem_rea  = cur.is_load;
      mem_hold     = (state_q == WAIT) ? !mem.mem_rdy : 1'b1;
    end
  end

  load_align u_load_align (
    .dout        (mem.mem_dout),
    .offset      (req_q.addr[1:0]),
    .loadcntrl   (req_q.loadcntrl),
    .load_data_c (load_data_c)
  );

  // MEM/WB registers; regwrite defaults low so every stall edge is a bubble.
  always_ff @(posedge clk) begin
    if (Rst) begin
      req_q            <= '0;
      cnt_q            <= '0;
      bus_err          <= 1'b0;
      misalign         <= 1'b0;
      MEM_WB_rd        <= '0;
      MEM_WB_regwrite  <= 1'b0;
      MEM_WB_memread   <= 1'b0;
      MEM_WB_fpusrc    <= 1'b0;
      MEM_WB_CSR_read  <= 1'b0;
      MEM_WB_alures    <= '0;
      MEM_WB_memres    <= '0;
      MEM_WB_pres_addr <= '0;
      MEM_WB_CSR       <= '0;
    end else begin
      bus_err         <= 1'b0;
      misalign        <= 1'b0;
      MEM_WB_regwrite <= 1'b0;
      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (issue_c) begin
          req_q <= ex_req;
        end else begin
          MEM_WB_rd        <= EX_MEM_rd;
          MEM_WB_regwrite  <= EX_MEM_regwrite & ~ex_access;
          MEM_WB_memread   <= ex_req.is_load;
          MEM_WB_fpusrc    <= EX_MEM_fpusrc;
          MEM_WB_CSR_read  <= EX_MEM_CSR_read;
          MEM_WB_alures    <= EX_MEM_alures;
          MEM_WB_memres    <= '0;
          MEM_WB_pres_addr <= EX_MEM_pres_addr;
          MEM_WB_CSR       <= EX_MEM_CSR;
          misalign         <= ex_access;
        end
      end else if (mem.mem_rdy || timeout_c) begin
        cnt_q            <= '0;
        MEM_WB_rd        <= req_q.rd;
        MEM_WB_regwrite  <= req_q.regwrite & mem.mem_rdy;
        MEM_WB_memread   <= req_q.is_load;
        MEM_WB_fpusrc    <= req_q.fpusrc;
        MEM_WB_CSR_read  <= req_q.csr_read;
        MEM_WB_alures    <= req_q.addr;
        MEM_WB_memres    <= (mem.mem_rdy && req_q.is_load) ? load_data_c : '0;
        MEM_WB_pres_addr <= req_q.pc;
        MEM_WB_CSR       <= req_q.csr;
        bus_err          <= timeout_c;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized accesses against a behavioural model.
module tb_mem_stage;

  localparam int unsigned TO = 8;
  localparam int K_NOP = 0, K_LB = 1, K_LH = 2, K_LW = 3, K_LBU = 4, K_LHU = 5, K_SB = 6, K_SH = 7, K_SW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Rst;
  logic [31:0] ex_alures, ex_rs2, ex_pc, ex_csr;
  logic [4:0]  ex_rd, ex_loadcntrl;
  logic [2:0]  ex_storecntrl;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_fpusrc, ex_csr_read;
  logic        mem_hold, bus_err, misalign;
  logic [4:0]  wb_rd;
  logic        wb_regwrite, wb_memread, wb_fpusrc, wb_csr_read;
  logic [31:0] wb_alures, wb_memres, wb_pc, wb_csr;

  mem_stage_if #(.XLEN(32)) bus ();

  mem_stage #(.TIMEOUT(TO), .XLEN(32)) dut (
    .clk(clk), .Rst(Rst),
    .EX_MEM_alures(ex_alures), .EX_MEM_dout_rs2(ex_rs2), .EX_MEM_rd(ex_rd),
    .EX_MEM_regwrite(ex_regwrite), .EX_MEM_memread(ex_memread), .EX_MEM_memwrite(ex_memwrite),
    .EX_MEM_loadcntrl(ex_loadcntrl), .EX_MEM_storecntrl(ex_storecntrl), .EX_MEM_pres_addr(ex_pc),
    .EX_MEM_fpusrc(ex_fpusrc), .EX_MEM_CSR(ex_csr), .EX_MEM_CSR_read(ex_csr_read),
    .mem(bus), .mem_hold(mem_hold), .bus_err(bus_err), .misalign(misalign),
    .MEM_WB_rd(wb_rd), .MEM_WB_regwrite(wb_regwrite), .MEM_WB_memread(wb_memread),
    .MEM_WB_fpusrc(wb_fpusrc), .MEM_WB_CSR_read(wb_csr_read), .MEM_WB_alures(wb_alures),
    .MEM_WB_memres(wb_memres), .MEM_WB_pres_addr(wb_pc), .MEM_WB_CSR(wb_csr)
  );

  int checks = 0;
  int errors = 0;

  // Values driven for the current op and what the DUT showed for it.
  logic [4:0]  d_rd;
  logic [31:0] d_pc, d_csr;
  logic        d_regwrite, d_fpusrc, d_csr_read;
  logic [31:0] o_addr, o_din;
  logic [3:0]  o_en;
  logic        o_wea, o_rea, o_stable, o_done;
  int          o_hold, o_mis, o_err;

  // Behavioural model of the access rules.
  function automatic int ksize(input int k);
    case (k)
      K_LB, K_LBU, K_SB: return 1;
      K_LH, K_LHU, K_SH: return 2;
      K_LW, K_SW:        return 4;
      default:           return 0;
    endcase
  endfunction

  function automatic bit kload(input int k);  return (k >= K_LB) && (k <= K_LHU); endfunction
  function automatic bit kstore(input int k); return k >= K_SB; endfunction
  function automatic bit kalign(input int k, input logic [31:0] a);
    return (ksize(k) == 0) || ((a % ksize(k)) == 0);
  endfunction

  function automatic logic [3:0] exp_en(input int k, input logic [31:0] a);
    int unsigned off;
    off = a % 4;
    if (k == K_SB) return 4'(1 << off);
    if (k == K_SH) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_din(input int k, input logic [31:0] rs2);
    if (k == K_SB) return (rs2 & 32'hFF) * 32'h01010101;
    if (k == K_SH) return (rs2 & 32'hFFFF) * 32'h00010001;
    return rs2;
  endfunction

  function automatic logic [31:0] exp_load(input int k, input logic [31:0] a, input logic [31:0] w);
    int unsigned off;
    logic [31:0] b, h;
    off = a % 4;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (k)
      K_LB:    return (b >= 128) ? b - 256 : b;
      K_LH:    return (h >= 32768) ? h - 65536 : h;
      K_LBU:   return b;
      K_LHU:   return h;
      K_LW:    return w;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive_nop();
    ex_alures = 0; ex_rs2 = 0; ex_pc = 0; ex_csr = 0; ex_rd = 0;
    ex_loadcntrl = 0; ex_storecntrl = 0;
    ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0; ex_fpusrc = 0; ex_csr_read = 0;
  endtask

  task automatic set_ex(input int k, input logic [31:0] addr, input logic [31:0] rs2);
    ex_loadcntrl = 0; ex_storecntrl = 0;
    case (k)
      K_LB:  ex_loadcntrl  = 5'b00001;
      K_LH:  ex_loadcntrl  = 5'b00010;
      K_LW:  ex_loadcntrl  = 5'b00100;
      K_LBU: ex_loadcntrl  = 5'b01000;
      K_LHU: ex_loadcntrl  = 5'b10000;
      K_SB:  ex_storecntrl = 3'b001;
      K_SH:  ex_storecntrl = 3'b010;
      K_SW:  ex_storecntrl = 3'b100;
      default: ;
    endcase
    d_rd = 5'($urandom_range(1, 31)); d_pc = $urandom & 32'hFFFFFFFC; d_csr = $urandom;
    d_regwrite = !kstore(k); d_fpusrc = 1'($urandom_range(0, 1)); d_csr_read = 1'($urandom_range(0, 1));
    ex_alures = addr; ex_rs2 = rs2; ex_rd = d_rd; ex_pc = d_pc; ex_csr = d_csr;
    ex_regwrite = d_regwrite; ex_fpusrc = d_fpusrc; ex_csr_read = d_csr_read;
    ex_memread = kload(k); ex_memwrite = kstore(k);
  endtask

  // Presents one op, holds it while mem_hold is up, answers rdy after 'lat' wait cycles.
  task automatic do_access(input int k, input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [31:0] dout, input int lat);
    logic hold;
    set_ex(k, addr, rs2);
    bus.mem_rdy = 1'b0; bus.mem_dout = $urandom;
    #1;
    o_addr = bus.mem_addr; o_en = bus.mem_en; o_din = bus.mem_din;
    o_wea = bus.mem_wea; o_rea = bus.mem_rea; hold = mem_hold;
    o_hold = 0; o_mis = 0; o_err = 0; o_stable = 1'b1; o_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (hold) o_hold++;
      @(posedge clk); #1;
      if (misalign) o_mis++;
      if (bus_err) o_err++;
      if (!hold || bus_err) begin o_done = 1'b1; break; end
      bus.mem_rdy  = (c == lat);
      bus.mem_dout = (c == lat) ? dout : $urandom;
      #1;
      hold = mem_hold;
      if (bus.mem_addr !== o_addr || bus.mem_en !== o_en || bus.mem_din !== o_din ||
          bus.mem_wea !== o_wea || bus.mem_rea !== o_rea) o_stable = 1'b0;
    end
    drive_nop();
    bus.mem_rdy = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; drive_nop(); bus.mem_rdy = 1'b0; bus.mem_dout = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wb_regwrite !== 1'b0 || wb_rd !== 5'd0 || wb_memread !== 1'b0) begin errors++; $display("FAIL reset_wb_ctrl got rw=%b rd=%0d mr=%b exp 0", wb_regwrite, wb_rd, wb_memread); end
    checks++; if (wb_alures !== 32'h0 || wb_memres !== 32'h0 || wb_pc !== 32'h0 || wb_csr !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h %h %h %h exp 0", wb_alures, wb_memres, wb_pc, wb_csr); end
    checks++; if (bus.mem_wea !== 1'b0 || bus.mem_rea !== 1'b0 || bus.mem_en !== 4'h0 || mem_hold !== 1'b0) begin errors++; $display("FAIL reset_bus got wea=%b rea=%b en=%h hold=%b exp 0", bus.mem_wea, bus.mem_rea, bus.mem_en, mem_hold); end
    checks++; if (bus_err !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL reset_pulses got err=%b mis=%b exp 0", bus_err, misalign); end
    Rst = 1'b0;
  endtask

  task automatic test_nonmem();
    do_access(K_NOP, 32'h12345678, 32'h0, 32'h0, 0);
    checks++; if (wb_alures !== 32'h12345678) begin errors++; $display("FAIL nonmem_alures got %h exp 12345678", wb_alures); end
    checks++; if (wb_rd !== d_rd || wb_regwrite !== 1'b1) begin errors++; $display("FAIL nonmem_rd got rd=%0d rw=%b exp rd=%0d rw=1", wb_rd, wb_regwrite, d_rd); end
    checks++; if (o_hold !== 0) begin errors++; $display("FAIL nonmem_hold got %0d exp 0", o_hold); end
  endtask

  task automatic test_store_byte();
    do_access(K_SB, 32'h103, 32'hAABBCCDD, 32'h0, 3);
    checks++; if (o_addr !== 32'h100 || o_en !== 4'b1000) begin errors++; $display("FAIL sb_addr_en got %h/%b exp 00000100/1000", o_addr, o_en); end
    checks++; if (o_din !== 32'hDDDDDDDD || o_wea !== 1'b1 || o_rea !== 1'b0) begin errors++; $display("FAIL sb_din got %h wea=%b rea=%b exp DDDDDDDD 1 0", o_din, o_wea, o_rea); end
    checks++; if (o_hold !== 4 || !o_stable) begin errors++; $display("FAIL sb_hold got %0d stable=%b exp 4 1", o_hold, o_stable); end
    checks++; if (wb_regwrite !== 1'b0 || wb_memres !== 32'h0) begin errors++; $display("FAIL sb_wb got rw=%b res=%h exp 0 0", wb_regwrite, wb_memres); end
  endtask

  task automatic test_load_ext();
    do_access(K_LB, 32'h202, 32'h0, 32'h00F00000, 1);
    checks++; if (wb_memres !== 32'hFFFFFFF0 || wb_regwrite !== 1'b1) begin errors++; $display("FAIL lb_sext got %h rw=%b exp FFFFFFF0 1", wb_memres, wb_regwrite); end
    do_access(K_LBU, 32'h202, 32'h0, 32'h00F00000, 0);
    checks++; if (wb_memres !== 32'h000000F0) begin errors++; $display("FAIL lbu_zext got %h exp 000000F0", wb_memres); end
  endtask

  task automatic test_misalign();
    do_access(K_LH, 32'h101, 32'h0, 32'h0, 0);
    checks++; if (o_mis !== 1 || o_rea !== 1'b0) begin errors++; $display("FAIL lh_misalign got pulses=%0d rea=%b exp 1 0", o_mis, o_rea); end
    checks++; if (wb_regwrite !== 1'b0 || o_hold !== 0) begin errors++; $display("FAIL lh_mis_wb got rw=%b hold=%0d exp 0 0", wb_regwrite, o_hold); end
  endtask

  task automatic test_timeout();
    do_access(K_LW, 32'h400, 32'h0, 32'h0, 1000);
    checks++; if (o_done !== 1'b1 || o_err !== 1) begin errors++; $display("FAIL lw_timeout got done=%b err=%0d exp 1 1", o_done, o_err); end
    checks++; if (o_hold !== int'(TO) + 1) begin errors++; $display("FAIL lw_timeout_hold got %0d exp %0d", o_hold, TO + 1); end
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL lw_timeout_rw got %b exp 0", wb_regwrite); end
    do_access(K_NOP, 32'h55, 32'h0, 32'h0, 0);
    checks++; if (o_hold !== 0 || wb_alures !== 32'h55 || bus_err !== 1'b0) begin errors++; $display("FAIL post_timeout_idle got hold=%0d alu=%h err=%b exp 0 55 0", o_hold, wb_alures, bus_err); end
  endtask

  task automatic test_reset_in_wait();
    set_ex(K_LW, 32'h300, 32'h0);
    bus.mem_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    Rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (wb_regwrite !== 1'b0 || wb_alures !== 32'h0 || wb_rd !== 5'd0 || mem_hold !== 1'b0 || bus.mem_rea !== 1'b0) begin errors++; $display("FAIL rst_wait got rw=%b alu=%h rd=%0d hold=%b rea=%b exp 0", wb_regwrite, wb_alures, wb_rd, mem_hold, bus.mem_rea); end
    Rst = 1'b0; drive_nop(); bus.mem_rdy = 1'b1; bus.mem_dout = 32'hDEADBEEF;
    #1;
    checks++; if (mem_hold !== 1'b0 || bus.mem_rea !== 1'b0) begin errors++; $display("FAIL rst_wait_idle got hold=%b rea=%b exp 0 0", mem_hold, bus.mem_rea); end
    @(posedge clk); #1;
    checks++; if (wb_regwrite !== 1'b0 || wb_memres !== 32'h0 || bus_err !== 1'b0) begin errors++; $display("FAIL rst_wait_late_rdy got rw=%b res=%h err=%b exp 0 0 0", wb_regwrite, wb_memres, bus_err); end
    bus.mem_rdy = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int k, lat, hexp;
      logic [31:0] addr, rs2, dout, rexp;
      bit acc, ok, fin;
      k = $urandom_range(0, 8);
      addr = $urandom; rs2 = $urandom; dout = $urandom;
      lat = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, 4);
      acc = (k != K_NOP); ok = acc && kalign(k, addr); fin = ok && (lat < int'(TO));
      hexp = ok ? ((lat < int'(TO)) ? lat : int'(TO)) + 1 : 0;
      rexp = (fin && kload(k)) ? exp_load(k, addr, dout) : 32'h0;
      do_access(k, addr, rs2, dout, lat);
      checks++; if (o_done !== 1'b1 || o_hold !== hexp) begin errors++; $display("FAIL rnd_hold n=%0d k=%0d got done=%b hold=%0d exp 1 %0d", n, k, o_done, o_hold, hexp); end
      checks++; if (o_mis !== int'(acc && !ok) || o_err !== int'(ok && !fin)) begin errors++; $display("FAIL rnd_pulses n=%0d k=%0d got mis=%0d err=%0d exp %0d %0d", n, k, o_mis, o_err, acc && !ok, ok && !fin); end
      if (ok) begin
        checks++; if (o_addr !== (addr & 32'hFFFFFFFC) || o_en !== exp_en(k, addr) || o_wea !== kstore(k) || o_rea !== kload(k) || !o_stable) begin errors++; $display("FAIL rnd_req n=%0d k=%0d got %h/%b/%b/%b st=%b exp %h/%b", n, k, o_addr, o_en, o_wea, o_rea, o_stable, addr & 32'hFFFFFFFC, exp_en(k, addr)); end
        if (kstore(k)) begin
          checks++; if (o_din !== exp_din(k, rs2)) begin errors++; $display("FAIL rnd_din n=%0d k=%0d got %h exp %h", n, k, o_din, exp_din(k, rs2)); end
        end
      end else if (acc) begin
        checks++; if (o_wea !== 1'b0 || o_rea !== 1'b0) begin errors++; $display("FAIL rnd_mis_req n=%0d got wea=%b rea=%b exp 0 0", n, o_wea, o_rea); end
      end
      checks++; if (wb_memres !== rexp || wb_regwrite !== (d_regwrite && (!acc || fin))) begin errors++; $display("FAIL rnd_wb n=%0d k=%0d got res=%h rw=%b exp %h %b", n, k, wb_memres, wb_regwrite, rexp, d_regwrite && (!acc || fin)); end
      checks++; if (wb_rd !== d_rd || wb_alures !== addr || wb_pc !== d_pc || wb_csr !== d_csr || wb_memread !== kload(k) || wb_fpusrc !== d_fpusrc || wb_csr_read !== d_csr_read) begin errors++; $display("FAIL rnd_fields n=%0d k=%0d got rd=%0d alu=%h pc=%h csr=%h mr=%b", n, k, wb_rd, wb_alures, wb_pc, wb_csr, wb_memread); end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_store_byte();
    test_load_ext();
    test_misalign();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the Execute stage.
- Consumes the EX/MEM register outputs and runs loads and stores against the data-memory port using a request/ready handshake.
- Produces the MEM/WB register set for writeback.
- Asserts mem_hold to stall upstream stages while an access is outstanding.

Parameters:
- TIMEOUT, 64: max cycles waiting for mem_rdy before bus_err.
- XLEN, 32: datapath width.

Ports:
- clk  in  1  core clock
- Rst  in  1  synchronous active-high reset
- EX_MEM_alures  in  32  effective address / ALU result
- EX_MEM_dout_rs2  in  32  store data
- EX_MEM_rd  in  5  destination register
- EX_MEM_regwrite  in  1  writeback enable
- EX_MEM_memread  in  1  load
- EX_MEM_memwrite  in  1  store
- EX_MEM_loadcntrl  in  5  one-hot {lhu,lbu,lw,lh,lb}, bit0=lb
- EX_MEM_storecntrl  in  3  one-hot {sw,sh,sb}, bit0=sb
- EX_MEM_pres_addr  in  32  instruction PC
- EX_MEM_fpusrc  in  1  FP destination flag
- EX_MEM_CSR  in  32  CSR old value
- EX_MEM_CSR_read  in  1  CSR read flag
- mem_dout  in  32  read data
- mem_rdy  in  1  access complete
- mem_addr  out  32  word-aligned address
- mem_din  out  32  lane-replicated store data
- mem_en  out  4  byte enables
- mem_wea  out  1  write request
- mem_rea  out  1  read request
- mem_hold  out  1  pipeline stall
- bus_err  out  1  one-cycle timeout pulse
- misalign  out  1  one-cycle misaligned-access pulse
- MEM_WB_rd  out  5
- MEM_WB_regwrite  out  1
- MEM_WB_memread  out  1
- MEM_WB_fpusrc  out  1
- MEM_WB_CSR_read  out  1
- MEM_WB_alures  out  32
- MEM_WB_memres  out  32
- MEM_WB_pres_addr  out  32
- MEM_WB_CSR  out  32

Behaviour:
- Reset:
  - All MEM_WB_* outputs are 0.
  - mem_wea, mem_rea, mem_en, mem_hold, bus_err and misalign are 0.
  - State is IDLE and the timeout counter is 0.
  - Rst while in WAIT abandons the access immediately; no MEM_WB update occurs.
- Alignment:
  - sh/lh/lhu with addr[0]=1 is misaligned.
  - sw/lw with addr[1:0]!=0 is misaligned.
- IDLE, no access: the MEM_WB registers load from EX_MEM on the next edge (1-cycle latency). mem_hold=0.
- IDLE, aligned access:
  - Combinationally drive mem_addr={addr[31:2],2'b00}.
  - Drive mem_rea=memread and mem_wea=memwrite.
  - Drive mem_en and mem_din as below.
  - Assert mem_hold=1.
  - Latch the request (addr, size/sign, rd, PC, flags) and go to WAIT. MEM_WB_regwrite=0 for that edge (bubble).
- IDLE, misaligned access:
  - No memory request; misalign=1 for one cycle.
  - MEM_WB updated with MEM_WB_regwrite=0; state stays IDLE.
- WAIT:
  - Keep driving the latched request.
  - mem_hold = ~mem_rdy.
  - Counter increments each cycle.
- WAIT with mem_rdy=1:
  - MEM_WB_memres = extracted load data (0 for stores). All other MEM_WB fields come from the latched request.
  - Go to IDLE and clear the counter.
  - The new EX_MEM contents are presented the following cycle.
- WAIT with counter==TIMEOUT-1 and no rdy:
  - bus_err=1 for one cycle; MEM_WB_regwrite=0.
  - Go to IDLE and deassert the request.
- mem_rdy outside WAIT is ignored.
- Simultaneous memread and memwrite: memwrite wins and no load data is returned.
- Store lanes (o = addr[1:0]):
  - sb: mem_en=4'b0001<<o, mem_din={4{rs2[7:0]}}.
  - sh: mem_en=4'b0011<<o, mem_din={2{rs2[15:0]}}.
  - sw: mem_en=4'b1111, mem_din=rs2.
  - Loads: mem_en=4'b1111.
- Load extraction uses the latched addr[1:0]:
  - lb/lh: sign-extend byte/half.
  - lbu/lhu: zero-extend.
  - lw: the full word.
- The MEM_WB_regwrite bubble is mandatory on every stall edge so WB never writes twice.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE, WAIT);
  - LOAD_* / STORE_* one-hot bit-index constants;
  - the byte-lane enable function.
- One sub-module is natural: load_align (combinational), taking mem_dout, offset and loadcntrl and producing the extended result.

Test Plan:
- Non-memory op: alures=0x12345678, rd=5, regwrite=1 → next edge MEM_WB_alures=0x12345678, MEM_WB_rd=5, mem_hold stays 0.
- sb with addr=0x103, rs2=0xAABBCCDD → mem_addr=0x100, mem_en=4'b1000, mem_din=0xDDDDDDDD, wea=1.
  - mem_rdy asserted after 3 cycles → mem_hold high for exactly those cycles.
- lb at 0x202 with mem_dout=0x00F00000 → MEM_WB_memres=0xFFFFFFF0.
  - The same access as lbu → 0x000000F0.
- lh at 0x101 → misalign pulses once, no mem_rea, MEM_WB_regwrite=0, mem_hold=0.
- lw with mem_rdy never asserted, TIMEOUT=8 → mem_hold high for 8 cycles, then bus_err pulses, state returns to IDLE and MEM_WB_regwrite=0.
- Rst asserted during WAIT → next cycle all outputs 0 and state IDLE; a later mem_rdy has no effect.
